// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_skid_reg                                                |
// | Description : One-entry skid-buffered pipeline register. A main slot drives|
// |               the outputs and a skid slot absorbs the payload accepted     |
// |               while downstream stalls, so upstream ready is registered     |
// |               (it never depends on i_ready). Includes a flush, and a       |
// |               saturating stall counter with clear.                         |
// |               Optional macro PIPE_SKID_DEBUG_EN adds debug pc/inst fields  |
// |               that travel with the payload.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              ready,
  input  logic              i_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef PIPE_SKID_DEBUG_EN
  ,
  input  logic [31:0]       i_debug_pc,
  input  logic [31:0]       i_debug_inst,
  output logic [31:0]       debug_pc,
  output logic [31:0]       debug_inst
`endif
);

  // Debug fields are packed above the payload so they share the exact
  // slot movement of the data they belong to.
`ifdef PIPE_SKID_DEBUG_EN
  localparam int PAY_W = DATA_W + 64;
`else
  localparam int PAY_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PAY_W-1:0] in_pay;
  logic             accept;

  logic             main_valid_q, main_valid_d;
  logic [PAY_W-1:0] main_pay_q,   main_pay_d;
  logic             skid_valid_q, skid_valid_d;
  logic [PAY_W-1:0] skid_pay_q,   skid_pay_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

`ifdef PIPE_SKID_DEBUG_EN
  assign in_pay     = {i_debug_inst, i_debug_pc, i_data};
  assign debug_pc   = main_pay_q[DATA_W +: 32];
  assign debug_inst = main_pay_q[DATA_W+32 +: 32];
`else
  assign in_pay     = i_data;
`endif

  // Ready only reflects skid occupancy (and reset), never downstream ready.
  assign ready     = i_rst_n & ~skid_valid_q;
  assign accept    = i_valid & ready;

  assign valid     = main_valid_q;
  assign data      = main_pay_q[DATA_W-1:0];
  assign stall_cnt = cnt_q;

  // Slot next-state: flush wins, then drain/refill main, else park in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_pay_d   = main_pay_q;
    skid_valid_d = skid_valid_q;
    skid_pay_d   = skid_pay_q;

    if (i_flush) begin
      // Payload registers keep their contents; only the valid flags drop.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || i_ready) begin
      if (skid_valid_q) begin
        // Older skid payload moves first; a simultaneous accept refills the
        // skid so ordering is preserved.
        main_valid_d = 1'b1;
        main_pay_d   = skid_pay_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_pay_d = in_pay;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_pay_d   = in_pay;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main is stalled: the accepted payload waits in the skid slot.
      skid_valid_d = 1'b1;
      skid_pay_d   = in_pay;
    end
  end

  // Stall counter next-state: clear beats a saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (main_valid_q && !i_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous active-low reset clearing every slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      main_valid_q <= 1'b0;
      main_pay_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_pay_q   <= '0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pay_q   <= main_pay_d;
      skid_valid_q <= skid_valid_d;
      skid_pay_q   <= skid_pay_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_skid_reg                                             |
// | Description : Directed self-checking bench for pipe_skid_reg. A second     |
// |               instance with CNT_W=2 shares the stimulus to observe stall   |
// |               counter saturation. Honours PIPE_SKID_DEBUG_EN if defined.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_pipe_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready_in;
  logic        flush;
  logic        cnt_clr;

  logic        rdy;
  logic        vld;
  logic [31:0] dat;
  logic [15:0] cnt;

  logic        rdy2;
  logic        vld2;
  logic [31:0] dat2;
  logic [1:0]  cnt2;

  int total;
  int bad;

`ifdef PIPE_SKID_DEBUG_EN
  logic [31:0] dbg_pc_in, dbg_inst_in, dbg_pc, dbg_inst, dbg_pc2, dbg_inst2;
  assign dbg_pc_in   = in_data + 32'h0000_1000;
  assign dbg_inst_in = ~in_data;
`endif

  pipe_skid_reg #(.DATA_W(32), .CNT_W(16)) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .i_data    (in_data),
    .ready     (rdy),
    .i_ready   (out_ready_in),
    .valid     (vld),
    .data      (dat),
    .i_flush   (flush),
    .i_cnt_clr (cnt_clr),
    .stall_cnt (cnt)
`ifdef PIPE_SKID_DEBUG_EN
    ,
    .i_debug_pc  (dbg_pc_in),
    .i_debug_inst(dbg_inst_in),
    .debug_pc    (dbg_pc),
    .debug_inst  (dbg_inst)
`endif
  );

  pipe_skid_reg #(.DATA_W(32), .CNT_W(2)) u_dut2 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .i_data    (in_data),
    .ready     (rdy2),
    .i_ready   (out_ready_in),
    .valid     (vld2),
    .data      (dat2),
    .i_flush   (flush),
    .i_cnt_clr (cnt_clr),
    .stall_cnt (cnt2)
`ifdef PIPE_SKID_DEBUG_EN
    ,
    .i_debug_pc  (dbg_pc_in),
    .i_debug_inst(dbg_inst_in),
    .debug_pc    (dbg_pc2),
    .debug_inst  (dbg_inst2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h77; out_ready_in = 1'b1;
    flush = 1'b0; cnt_clr = 1'b0;
    step(); step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", vld); end
    total++; if (dat !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", dat); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", rdy); end
    total++; if (cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", cnt); end
`ifdef PIPE_SKID_DEBUG_EN
    total++; if (dbg_pc !== 32'h0 || dbg_inst !== 32'h0) begin bad++; $display("FAIL reset_debug got=%0h/%0h exp=0/0", dbg_pc, dbg_inst); end
`endif
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL release_ready got=%0h exp=1", rdy); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hA5; out_ready_in = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (vld !== 1'b1 || dat !== 32'hA5) begin bad++; $display("FAIL single_out got=%0h/%0h exp=1/a5", vld, dat); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready got=%0h exp=1", rdy); end
    step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL single_drain got=%0h exp=0", vld); end
  endtask

  task automatic test_back_to_back();
    out_ready_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = k;
      step();
      total++; if (vld !== 1'b1 || dat !== k) begin bad++; $display("FAIL b2b_out%0d got=%0h/%0h exp=1/%0h", k, vld, dat, k); end
`ifdef PIPE_SKID_DEBUG_EN
      total++; if (dbg_pc !== k + 32'h1000 || dbg_inst !== ~k) begin bad++; $display("FAIL b2b_debug%0d got=%0h/%0h", k, dbg_pc, dbg_inst); end
`endif
    end
    in_valid = 1'b0;
    step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h exp=0", vld); end
  endtask

  task automatic test_stall();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 32'd1; out_ready_in = 1'b1;
    step();
    out_ready_in = 1'b0; in_data = 32'd2;
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL stall_pre_ready got=%0h exp=1", rdy); end
    step();
    in_data = 32'd3;
    total++; if (rdy !== 1'b0 || vld !== 1'b1 || dat !== 32'd1) begin bad++; $display("FAIL stall_hold got=%0h/%0h/%0h exp=0/1/1", rdy, vld, dat); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL stall_cnt1 got=%0d exp=1", cnt); end
    step();
    total++; if (cnt !== 16'd2 || rdy !== 1'b0) begin bad++; $display("FAIL stall_cnt2 got=%0d/%0h exp=2/0", cnt, rdy); end
    step();
    total++; if (cnt !== 16'd3 || dat !== 32'd1) begin bad++; $display("FAIL stall_cnt3 got=%0d/%0h exp=3/1", cnt, dat); end
    out_ready_in = 1'b1;
    step();
    total++; if (vld !== 1'b1 || dat !== 32'd2 || rdy !== 1'b1) begin bad++; $display("FAIL resume_out2 got=%0h/%0h/%0h exp=1/2/1", vld, dat, rdy); end
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL resume_cnt got=%0d exp=3", cnt); end
`ifdef PIPE_SKID_DEBUG_EN
    total++; if (dbg_pc !== 32'h1002 || dbg_inst !== ~32'd2) begin bad++; $display("FAIL resume_debug got=%0h/%0h", dbg_pc, dbg_inst); end
`endif
    step();
    in_valid = 1'b0;
    total++; if (vld !== 1'b1 || dat !== 32'd3) begin bad++; $display("FAIL resume_out3 got=%0h/%0h exp=1/3", vld, dat); end
    step();
    total++; if (vld !== 1'b0) begin bad++; $display("FAIL resume_drain got=%0h exp=0", vld); end
  endtask

  task automatic test_flush();
    out_ready_in = 1'b0; in_valid = 1'b1; in_data = 32'd5;
    step();
    in_data = 32'd6;
    step();
    total++; if (rdy !== 1'b0 || vld !== 1'b1 || dat !== 32'd5) begin bad++; $display("FAIL flush_full got=%0h/%0h/%0h exp=0/1/5", rdy, vld, dat); end
    flush = 1'b1; in_data = 32'd9;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready_in = 1'b1;
    total++; if (vld !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL flush_clear got=%0h/%0h exp=0/1", vld, rdy); end
    total++; if (dat !== 32'd5) begin bad++; $display("FAIL flush_datahold got=%0h exp=5", dat); end
`ifdef PIPE_SKID_DEBUG_EN
    total++; if (dbg_pc !== 32'h1005 || dbg_inst !== ~32'd5) begin bad++; $display("FAIL flush_debug got=%0h/%0h", dbg_pc, dbg_inst); end
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (vld !== 1'b0) begin bad++; $display("FAIL flush_noleak%0d got=%0h/%0h exp=0", k, vld, dat); end
    end
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++; if (cnt !== 16'd0 || cnt2 !== 2'd0) begin bad++; $display("FAIL sat_clr0 got=%0d/%0d exp=0/0", cnt, cnt2); end
    in_valid = 1'b1; in_data = 32'h11; out_ready_in = 1'b0;
    step();
    in_valid = 1'b0;
    total++; if (cnt !== 16'd0 || vld !== 1'b1) begin bad++; $display("FAIL sat_load got=%0d/%0h exp=0/1", cnt, vld); end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++; if (cnt2 !== ((k > 3) ? 2'd3 : 2'(k))) begin bad++; $display("FAIL sat_cnt2_%0d got=%0d exp=%0d", k, cnt2, (k > 3) ? 3 : k); end
    end
    total++; if (cnt !== 16'd6) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=6", cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total++; if (cnt !== 16'd0 || cnt2 !== 2'd0) begin bad++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", cnt, cnt2); end
    out_ready_in = 1'b1;
    step();
    total++; if (vld !== 1'b0 || cnt !== 16'd0) begin bad++; $display("FAIL sat_drain got=%0h/%0d exp=0/0", vld, cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready_in = 1'b0; in_valid = 1'b1; in_data = 32'h21;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b0;
    total++; if (rdy !== 1'b0 || cnt === 16'd0) begin bad++; $display("FAIL mid_full got=%0h/%0d exp=0/nonzero", rdy, cnt); end
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h33; flush = 1'b1; cnt_clr = 1'b0;
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL mid_ready_comb got=%0h exp=0", rdy); end
    step();
    total++; if (vld !== 1'b0 || dat !== 32'h0 || rdy !== 1'b0) begin bad++; $display("FAIL mid_outs got=%0h/%0h/%0h exp=0/0/0", vld, dat, rdy); end
    total++; if (cnt !== 16'd0 || cnt2 !== 2'd0) begin bad++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", cnt, cnt2); end
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (vld !== 1'b0 || rdy !== 1'b1) begin bad++; $display("FAIL mid_noskid%0d got=%0h/%0h exp=0/1", k, vld, rdy); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready_in = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
